// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS main controller and the
// shared datapath plus unified memory.
interface mips_multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALU_op;
  logic        ALU_src_a;
  logic [1:0]  ALU_src_b;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic [1:0]  pc_source;
  logic        pc_en;
  logic        instr_retired;
  logic        illegal_op;
  logic        mem_err;
  logic [31:0] retired_count;

  modport master (
    input  opcode, zero, mem_ready,
    output ALU_op, ALU_src_a, ALU_src_b, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, pc_source, pc_en,
           instr_retired, illegal_op, mem_err, retired_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALU_op, ALU_src_a, ALU_src_b, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, pc_source, pc_en,
           instr_retired, illegal_op, mem_err, retired_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS: sequences fetch/decode/execute/
// memory/writeback over a shared datapath and stalls on memory ready.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic                     clk,
  input logic                     rst,
  mips_multicycle_ctrl_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
    MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic [31:0]        retired_cnt_r;
  logic               timeout_s, mem_wait_s;
  logic [1:0]         alu_op_s, alu_src_b_s, pc_source_s;
  logic               alu_src_a_s, i_or_d_s, mem_read_s, mem_write_s, ir_write_s;
  logic               reg_dst_s, mem_to_reg_s, reg_write_s, pc_write_s, pc_write_cond_s;
  logic               instr_retired_s, illegal_op_s, mem_err_s, pc_en_s;

  // A stalled access gives up once the wait counter hits the last allowed cycle.
  assign timeout_s = (MEM_TIMEOUT > 0) && (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1));

  // Next-state and per-state control decode; mem_ready beats timeout in the same cycle.
  always_comb begin
    state_s         = state_r;
    alu_op_s        = 2'b00;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_write_s     = 1'b0;
    pc_source_s     = 2'b00;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    instr_retired_s = 1'b0;
    illegal_op_s    = 1'b0;
    mem_err_s       = 1'b0;
    mem_wait_s      = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_s    = DECODE;
        end else if (timeout_s) begin
          mem_err_s = 1'b1;
          state_s   = FETCH;
        end else begin
          mem_wait_s = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_R:          state_s = EXEC_R;
          OP_LW, OP_SW:  state_s = MEM_ADDR;
          OP_BEQ:        state_s = BRANCH;
          OP_J:          state_s = JUMP;
          OP_ADDI:       state_s = EXEC_I;
          default: begin
            illegal_op_s = 1'b1;
            state_s      = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
        state_s     = WB_R;
      end
      WB_R: begin
        reg_dst_s       = 1'b1;
        reg_write_s     = 1'b1;
        instr_retired_s = 1'b1;
        state_s         = FETCH;
      end
      EXEC_I: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        state_s     = WB_I;
      end
      WB_I: begin
        reg_write_s     = 1'b1;
        instr_retired_s = 1'b1;
        state_s         = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_LW) begin
          state_s = MEM_RD;
        end else begin
          state_s = MEM_WR;
        end
      end
      MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
        if (bus.mem_ready) begin
          state_s = WB_MEM;
        end else if (timeout_s) begin
          mem_err_s = 1'b1;
          state_s   = FETCH;
        end else begin
          mem_wait_s = 1'b1;
        end
      end
      WB_MEM: begin
        mem_to_reg_s    = 1'b1;
        reg_write_s     = 1'b1;
        instr_retired_s = 1'b1;
        state_s         = FETCH;
      end
      MEM_WR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        if (bus.mem_ready) begin
          instr_retired_s = 1'b1;
          state_s         = FETCH;
        end else if (timeout_s) begin
          mem_err_s = 1'b1;
          state_s   = FETCH;
        end else begin
          mem_wait_s = 1'b1;
        end
      end
      BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
        instr_retired_s = 1'b1;
        state_s         = FETCH;
      end
      JUMP: begin
        pc_write_s      = 1'b1;
        pc_source_s     = 2'b10;
        instr_retired_s = 1'b1;
        state_s         = FETCH;
      end
      default: begin
        state_s = FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory wait counter: counts stalled cycles, clears on completion, timeout or leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (mem_wait_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_r <= 32'd0;
    end else if (instr_retired_s) begin
      retired_cnt_r <= retired_cnt_r + 32'd1;
    end else begin
      retired_cnt_r <= retired_cnt_r;
    end
  end

  assign pc_en_s = pc_write_s | (pc_write_cond_s & bus.zero);

  // Every output is forced low while reset is held, independent of the state register.
  assign bus.ALU_op        = rst ? 2'b00 : alu_op_s;
  assign bus.ALU_src_a     = rst ? 1'b0  : alu_src_a_s;
  assign bus.ALU_src_b     = rst ? 2'b00 : alu_src_b_s;
  assign bus.i_or_d        = rst ? 1'b0  : i_or_d_s;
  assign bus.mem_read      = rst ? 1'b0  : mem_read_s;
  assign bus.mem_write     = rst ? 1'b0  : mem_write_s;
  assign bus.ir_write      = rst ? 1'b0  : ir_write_s;
  assign bus.reg_dst       = rst ? 1'b0  : reg_dst_s;
  assign bus.mem_to_reg    = rst ? 1'b0  : mem_to_reg_s;
  assign bus.reg_write     = rst ? 1'b0  : reg_write_s;
  assign bus.pc_source     = rst ? 2'b00 : pc_source_s;
  assign bus.pc_en         = rst ? 1'b0  : pc_en_s;
  assign bus.instr_retired = rst ? 1'b0  : instr_retired_s;
  assign bus.illegal_op    = rst ? 1'b0  : illegal_op_s;
  assign bus.mem_err       = rst ? 1'b0  : mem_err_s;
  assign bus.retired_count = rst ? 32'd0 : retired_cnt_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: builds an expected per-cycle trace from instruction-level
// rules (opcode, zero, memory wait lengths) and compares every DUT output each cycle.
module tb_mips_multicycle_ctrl;

  localparam int T = 4;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       instr_retired;
    logic       illegal_op;
    logic       mem_err;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    out_t       exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  cyc_t        tr[$];
  logic [5:0]  cur_op;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_cnt = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_ADDI;
  endfunction

  task automatic push(input out_t o, input logic rdy, input logic z);
    cyc_t c;
    c.rst = 1'b0; c.op = cur_op; c.z = z; c.rdy = rdy; c.exp = o;
    tr.push_back(c);
  endtask

  task automatic push_rst();
    cyc_t c;
    c.rst = 1'b1; c.op = 6'($urandom); c.z = rb(); c.rdy = 1'b1; c.exp = '0;
    tr.push_back(c);
  endtask

  // kind: 0 instruction fetch, 1 data read, 2 data write; waits = cycles before ready.
  task automatic mem_phase(input int kind, input int waits, output bit ok);
    out_t b;
    out_t o;
    b  = '0;
    ok = 1'b0;
    if (kind == 0) begin b.mem_read = 1'b1; b.src_b = 2'b01; end
    else if (kind == 1) begin b.mem_read = 1'b1; b.i_or_d = 1'b1; end
    else begin b.mem_write = 1'b1; b.i_or_d = 1'b1; end
    for (int i = 0; i <= waits; i++) begin
      o = b;
      if (i == waits) begin
        if (kind == 0) begin o.ir_write = 1'b1; o.pc_en = 1'b1; end
        else if (kind == 2) o.instr_retired = 1'b1;
        push(o, 1'b1, rb());
        ok = 1'b1;
        break;
      end else if (T > 0 && i == T - 1) begin
        o.mem_err = 1'b1;
        push(o, 1'b0, rb());
        break;
      end else begin
        push(o, 1'b0, rb());
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
    bit   ok;
    out_t o;
    cur_op = op;
    mem_phase(0, wf, ok);
    while (!ok) mem_phase(0, 0, ok);
    o = '0; o.src_b = 2'b11;
    if (!legal(op)) begin
      o.illegal_op = 1'b1;
      push(o, rb(), rb());
      return;
    end
    push(o, rb(), rb());
    o = '0;
    case (op)
      OP_R: begin
        o.src_a = 1'b1; o.alu_op = 2'b10; push(o, rb(), rb());
        o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_retired = 1'b1; push(o, rb(), rb());
      end
      OP_ADDI: begin
        o.src_a = 1'b1; o.src_b = 2'b10; push(o, rb(), rb());
        o = '0; o.reg_write = 1'b1; o.instr_retired = 1'b1; push(o, rb(), rb());
      end
      OP_LW: begin
        o.src_a = 1'b1; o.src_b = 2'b10; push(o, rb(), rb());
        mem_phase(1, wm, ok);
        if (ok) begin
          o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_retired = 1'b1;
          push(o, rb(), rb());
        end
      end
      OP_SW: begin
        o.src_a = 1'b1; o.src_b = 2'b10; push(o, rb(), rb());
        mem_phase(2, wm, ok);
      end
      OP_BEQ: begin
        o.src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = z;
        o.instr_retired = 1'b1; push(o, rb(), z);
      end
      default: begin
        o.pc_en = 1'b1; o.pc_source = 2'b10; o.instr_retired = 1'b1; push(o, rb(), rb());
      end
    endcase
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [6];
    logic [5:0] op;
    int k;
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;
    k = int'($urandom_range(0, 6));
    if (k < 6) return ops[k];
    op = 6'($urandom);
    while (legal(op)) op = 6'($urandom);
    return op;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T + 1)) : 0;
  endfunction

  initial begin
    bit   ok;
    out_t o;
    out_t got;
    logic [31:0] exp_cnt;
    bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    push_rst(); push_rst();
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 0, 3);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(OP_R, 1'b0, 6, 0);
    run_instr(OP_SW, 1'b0, 0, 2);
    run_instr(OP_J, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 0, 7);
    for (int n = 0; n < 400; n++) run_instr(rand_op(), rb(), rand_wait(), rand_wait());

    // Store stalled in its write phase, then reset lands mid-access.
    cur_op = OP_SW;
    mem_phase(0, 0, ok);
    o = '0; o.src_b = 2'b11; push(o, rb(), rb());
    o = '0; o.src_a = 1'b1; o.src_b = 2'b10; push(o, rb(), rb());
    o = '0; o.mem_write = 1'b1; o.i_or_d = 1'b1; push(o, 1'b0, rb());
    push_rst();
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_BEQ, 1'b1, 1, 0);

    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      rst           = tr[i].rst;
      bus.opcode    = tr[i].op;
      bus.zero      = tr[i].z;
      bus.mem_ready = tr[i].rdy;
      #1;
      got = {bus.ALU_op, bus.ALU_src_a, bus.ALU_src_b, bus.i_or_d, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
             bus.pc_source, bus.pc_en, bus.instr_retired, bus.illegal_op, bus.mem_err};
      check_eq($sformatf("ctl@%0d", i), 32'(got), 32'(tr[i].exp));
      exp_cnt = tr[i].rst ? 32'd0 : model_cnt;
      check_eq($sformatf("cnt@%0d", i), bus.retired_count, exp_cnt);
      if (tr[i].rst) model_cnt = 32'd0;
      else if (tr[i].exp.instr_retired) model_cnt = model_cnt + 32'd1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
